// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: buffers 32-bit big-endian words into 512-bit blocks, appends 0x80/zero/length, replays each block to the core.
// Latency: PAD 15-k cycles after last word at index k, EMIT 16 cycles; in_ready low outside COLLECT, next block waits for core_valid.
module sha1_msg_padder #(
    parameter int CNT_W = 61
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    input  logic        core_ready,
    input  logic        core_valid,
    output logic [31:0] out_data,
    output logic        out_start,
    output logic        out_restart,
    output logic        out_final,
    output logic        msg_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        COLLECT,
        PAD,
        WAIT_CORE,
        EMIT,
        WAIT_HASH
    } state_t;

    state_t           state_q;
    logic [4:0]       wi_q;
    logic [3:0]       ri_q;
    logic             first_q;
    logic             pad_done_q;
    logic             len_done_q;
    logic             core_busy_q;
    logic             last_seen_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      blk_q [16];

    logic [31:0]      out_data_q;
    logic             out_start_q;
    logic             out_restart_q;
    logic             out_final_q;
    logic             msg_done_q;
    logic             busy_q;

    logic             accept;
    logic             blk_we;
    logic [31:0]      blk_d;
    logic [31:0]      coll_word;
    logic [31:0]      pad_word;
    logic [63:0]      len_bits;
    logic [CNT_W-1:0] cnt_d;

    assign in_ready = (state_q == COLLECT) && !wi_q[4];
    assign accept   = in_valid && in_ready;
    assign cnt_d    = cnt_q + CNT_W'(in_bytes);

    // Keep the first in_bytes bytes, drop the 0x80 marker right after them.
    always_comb begin
        coll_word = '0;
        for (int p = 0; p < 4; p++) begin
            if (3'(p) < in_bytes) begin
                coll_word[31-8*p -: 8] = in_data[31-8*p -: 8];
            end else if (3'(p) == in_bytes) begin
                coll_word[31-8*p -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        len_bits               = '0;
        len_bits[CNT_W+2:0]    = {cnt_q, 3'b000};
    end

    // Length only fits when the marker landed at word 13 or earlier.
    always_comb begin
        pad_word = '0;
        if (!pad_done_q) begin
            pad_word = 32'h8000_0000;
        end else if (wi_q == 5'd14 && !len_done_q) begin
            pad_word = len_bits[63:32];
        end else if (wi_q == 5'd15 && len_done_q) begin
            pad_word = len_bits[31:0];
        end
    end

    assign blk_d  = (state_q == COLLECT) ? coll_word : pad_word;
    assign blk_we = !rst && (accept || (state_q == PAD));

    always_ff @(posedge clk) begin
        if (blk_we) begin
            blk_q[wi_q[3:0]] <= blk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            wi_q          <= '0;
            ri_q          <= '0;
            first_q       <= 1'b1;
            pad_done_q    <= 1'b0;
            len_done_q    <= 1'b0;
            core_busy_q   <= 1'b0;
            last_seen_q   <= 1'b0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_start_q   <= 1'b0;
            out_restart_q <= 1'b0;
            out_final_q   <= 1'b0;
            msg_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        wi_q   <= wi_q + 5'd1;
                        cnt_q  <= cnt_d;
                        busy_q <= 1'b1;
                        if (in_bytes < 3'd4) begin
                            pad_done_q <= 1'b1;
                        end
                        if (in_last) begin
                            last_seen_q <= 1'b1;
                            state_q     <= (wi_q == 5'd15) ? WAIT_CORE : PAD;
                        end else if (wi_q == 5'd15) begin
                            state_q <= WAIT_CORE;
                        end
                    end
                end
                PAD: begin
                    wi_q <= wi_q + 5'd1;
                    if (!pad_done_q) begin
                        pad_done_q <= 1'b1;
                    end else if (wi_q == 5'd14 && !len_done_q) begin
                        len_done_q <= 1'b1;
                    end
                    if (wi_q == 5'd15) begin
                        state_q <= WAIT_CORE;
                    end
                end
                WAIT_CORE: begin
                    if (core_ready && !core_busy_q) begin
                        state_q       <= EMIT;
                        ri_q          <= '0;
                        out_data_q    <= blk_q[0];
                        out_restart_q <= first_q;
                        out_start_q   <= !first_q;
                        out_final_q   <= len_done_q;
                    end
                end
                EMIT: begin
                    ri_q <= ri_q + 4'd1;
                    if (ri_q == 4'd15) begin
                        out_data_q    <= '0;
                        out_start_q   <= 1'b0;
                        out_restart_q <= 1'b0;
                        out_final_q   <= 1'b0;
                        core_busy_q   <= 1'b1;
                        first_q       <= 1'b0;
                        wi_q          <= '0;
                        state_q       <= WAIT_HASH;
                    end else begin
                        out_data_q <= blk_q[ri_q + 4'd1];
                    end
                end
                WAIT_HASH: begin
                    if (core_valid) begin
                        core_busy_q <= 1'b0;
                        if (len_done_q) begin
                            msg_done_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            cnt_q       <= '0;
                            pad_done_q  <= 1'b0;
                            len_done_q  <= 1'b0;
                            last_seen_q <= 1'b0;
                            first_q     <= 1'b1;
                            state_q     <= COLLECT;
                        end else if (last_seen_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_start   = out_start_q;
    assign out_restart = out_restart_q;
    assign out_final   = out_final_q;
    assign msg_done    = msg_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder with a behavioural SHA-1 core that hashes the replayed blocks.
module tb_sha1_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        core_ready;
    logic        core_valid;
    logic [31:0] out_data;
    logic        out_start;
    logic        out_restart;
    logic        out_final;
    logic        msg_done;
    logic        busy;

    always #5 clk = ~clk;

    sha1_msg_padder #(.CNT_W(61)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .core_ready (core_ready),
        .core_valid (core_valid),
        .out_data   (out_data),
        .out_start  (out_start),
        .out_restart(out_restart),
        .out_final  (out_final),
        .msg_done   (msg_done),
        .busy       (busy)
    );

    localparam int LAT = 10;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] hs     [5];
    logic [31:0] cur_w  [16];
    logic [31:0] blk_w  [16][16];
    bit          blk_rst[16];
    bit          blk_fin[16];
    int          blk_len[16];
    logic [31:0] exp_w  [16];
    int          nb    = 0;
    int          ndone = 0;
    bit          stall = 1'b0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'hA5, 8'(i), 8'h5A, 8'(i + 1)};
    endfunction

    task automatic sha1_compress();
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = cur_w[i];
        for (int i = 16; i < 80; i++) begin
            t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = hs[0]; b = hs[1]; c = hs[2]; d = hs[3]; e = hs[4];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        hs[0] += a; hs[1] += b; hs[2] += c; hs[3] += d; hs[4] += e;
    endtask

    // Core model: captures each strobe window, hashes complete blocks, answers after LAT cycles.
    initial begin : core_model
        int wcnt, hold;
        bit in_blk, c_rst, c_fin;
        wcnt = 0; hold = 0; in_blk = 0; c_rst = 0; c_fin = 0;
        core_valid = 1'b0;
        core_ready = 1'b1;
        forever begin
            @(negedge clk);
            core_valid = 1'b0;
            if (rst) begin
                in_blk = 0; hold = 0; wcnt = 0;
            end else begin
                if (msg_done) ndone++;
                if (out_start || out_restart) begin
                    if (!in_blk) begin
                        in_blk = 1; wcnt = 0; c_rst = out_restart; c_fin = out_final;
                    end
                    if (wcnt < 16) cur_w[wcnt] = out_data;
                    wcnt++;
                end else if (in_blk) begin
                    in_blk = 0;
                    if (nb < 16) begin
                        for (int i = 0; i < 16; i++) blk_w[nb][i] = cur_w[i];
                        blk_rst[nb] = c_rst;
                        blk_fin[nb] = c_fin;
                        blk_len[nb] = wcnt;
                    end
                    nb++;
                    if (wcnt == 16) begin
                        if (c_rst) begin
                            hs[0] = 32'h67452301; hs[1] = 32'hEFCDAB89; hs[2] = 32'h98BADCFE;
                            hs[3] = 32'h10325476; hs[4] = 32'hC3D2E1F0;
                        end
                        sha1_compress();
                        hold = LAT;
                    end
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) core_valid = 1'b1;
                end
            end
            core_ready = !stall && !in_blk && (hold == 0);
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] nbytes, input bit last);
        int t = 0;
        in_data = d; in_bytes = nbytes; in_last = last; in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int t = 0;
        while (ndone < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, ndone, target);
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = '0;
    endtask

    task automatic check_blk(input string tag, input int idx, input bit er, input bit ef);
        chk({tag, "_seen"}, nb > idx, 1'b1);
        if (nb > idx && idx < 16) begin
            chk({tag, "_len"}, blk_len[idx], 16);
            chk({tag, "_restart"}, blk_rst[idx], er);
            chk({tag, "_final"}, blk_fin[idx], ef);
            for (int i = 0; i < 16; i++) chk($sformatf("%s_w%0d", tag, i), blk_w[idx][i], exp_w[i]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int b, d, t, stall_strobes;
        logic [31:0] tmp;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", {out_data, out_start, out_restart, out_final, msg_done, busy}, '0);

        // "abc"
        b = nb; d = ndone;
        send(32'h61626300, 3'd3, 1'b1);
        chk("abc_busy", busy, 1'b1);
        chk("abc_in_ready_pad", in_ready, 1'b0);
        wait_done(d + 1, "abc_done");
        chk("abc_busy_after", busy, 1'b0);
        clr_exp(); exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        check_blk("abc", b, 1'b1, 1'b1);
        chk("abc_digest", {hs[0], hs[1], hs[2], hs[3], hs[4]},
            160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        // empty message
        b = nb; d = ndone;
        send(32'h0, 3'd0, 1'b1);
        wait_done(d + 1, "empty_done");
        clr_exp(); exp_w[0] = 32'h80000000;
        check_blk("empty", b, 1'b1, 1'b1);
        chk("empty_digest", {hs[0], hs[1], hs[2], hs[3], hs[4]},
            160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);

        // 55 bytes: marker and length share the single block
        b = nb; d = ndone;
        for (int i = 0; i < 13; i++) send(pat(i), 3'd4, 1'b0);
        send(pat(13), 3'd3, 1'b1);
        wait_done(d + 1, "b55_done");
        clr_exp();
        for (int i = 0; i < 13; i++) exp_w[i] = pat(i);
        tmp = pat(13);
        exp_w[13] = {tmp[31:8], 8'h80};
        exp_w[15] = 32'h000001B8;
        check_blk("b55", b, 1'b1, 1'b1);

        // 56 bytes: length spills into a second block built in PAD
        b = nb; d = ndone;
        for (int i = 0; i < 14; i++) send(pat(i), 3'd4, i == 13);
        wait_done(d + 1, "b56_done");
        clr_exp();
        for (int i = 0; i < 14; i++) exp_w[i] = pat(i);
        exp_w[14] = 32'h80000000;
        check_blk("b56_blk1", b, 1'b1, 1'b0);
        clr_exp(); exp_w[15] = 32'h000001C0;
        check_blk("b56_blk2", b + 1, 1'b0, 1'b1);

        // 100 bytes, in_valid toggling, core_ready held low for 20 cycles
        b = nb; d = ndone; stall_strobes = 0;
        stall = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    send(pat(i), 3'd4, i == 24);
                    if (i < 24) @(negedge clk);
                end
            end
            begin
                t = 0;
                while (!(busy && !in_ready) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    if (out_start || out_restart) stall_strobes++;
                end
                stall = 1'b0;
            end
        join
        wait_done(d + 1, "b100_done");
        chk("b100_no_emit_while_stalled", stall_strobes, 0);
        clr_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = pat(i);
        check_blk("b100_blk1", b, 1'b1, 1'b0);
        clr_exp();
        for (int i = 0; i < 9; i++) exp_w[i] = pat(16 + i);
        exp_w[9]  = 32'h80000000;
        exp_w[15] = 32'h00000320;
        check_blk("b100_blk2", b + 1, 1'b0, 1'b1);

        // reset in the middle of EMIT, then a clean "abc"
        send(32'h61626300, 3'd3, 1'b1);
        t = 0;
        while (!(out_restart || out_start) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("rs_emit_seen", out_restart, 1'b1);
        repeat (7) @(negedge clk);
        chk("rs_in_ready_emit", in_ready, 1'b0);
        chk("rs_strobe_word7", out_restart, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_outputs", {out_data, out_start, out_restart, out_final, msg_done, busy}, '0);
        chk("rs_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        b = nb; d = ndone;
        send(32'h61626300, 3'd3, 1'b1);
        wait_done(d + 1, "abc2_done");
        clr_exp(); exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        check_blk("abc2", b, 1'b1, 1'b1);
        chk("abc2_digest", {hs[0], hs[1], hs[2], hs[3], hs[4]},
            160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
